// File: rtl/demux_regbank_loader_if.sv
// Bus bundle for demux_regbank_loader: two write channels, mode/control
// strobes and the loaded register banks with their status flags.
//
// Handshake: on each channel an element is transferred at a rising clk
// edge where valid and ready are both high. valid may be raised at any
// time; ready depends on the FSM state, the channel pointer and auto_mode
// only, never on valid, data or sel.
interface demux_regbank_loader_if #(
    parameter int DATA_W = 16,
    parameter int N_A    = 4,
    parameter int N_B    = 6,
    parameter int SEL_W  = 3
);
    logic                     a_valid;
    logic                     a_ready;
    logic [DATA_W-1:0]        a_data;
    logic [SEL_W-1:0]         a_sel;
    logic                     b_valid;
    logic                     b_ready;
    logic [DATA_W-1:0]        b_data;
    logic [SEL_W-1:0]         b_sel;
    logic                     auto_mode;
    logic                     clr;
    logic                     consume;
    logic [N_A*DATA_W-1:0]    a_out;
    logic [N_B*DATA_W-1:0]    b_out;
    logic [N_A-1:0]           a_loaded;
    logic [N_B-1:0]           b_loaded;
    logic                     bank_full;
    logic                     sel_err;
    // FSM state for observation: 0 = EMPTY, 1 = LOAD, 2 = FULL.
    logic [1:0]               state;

    modport master (
        output a_valid, a_data, a_sel, b_valid, b_data, b_sel,
               auto_mode, clr, consume,
        input  a_ready, b_ready, a_out, b_out, a_loaded, b_loaded,
               bank_full, sel_err, state
    );

    modport slave (
        input  a_valid, a_data, a_sel, b_valid, b_data, b_sel,
               auto_mode, clr, consume,
        output a_ready, b_ready, a_out, b_out, a_loaded, b_loaded,
               bank_full, sel_err, state
    );
endinterface

// File: rtl/demux_regbank_loader.sv
// Two-channel register bank loader. Each channel writes into its own bank,
// either at an explicit select or at an internal sequential pointer. Once
// every register of both banks is loaded the block stalls in FULL until the
// downstream consumes the bank set.
module demux_regbank_loader #(
    parameter int DATA_W = 16,
    parameter int N_A    = 4,
    parameter int N_B    = 6,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_regbank_loader_if.slave   bus_if
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Top select code clears the whole channel bank.
    localparam logic [SEL_W-1:0] SEL_CLR = '1;
    localparam logic [SEL_W-1:0] A_END   = SEL_W'(N_A);
    localparam logic [SEL_W-1:0] B_END   = SEL_W'(N_B);

    state_t              state_q;
    logic                bank_full_q;
    logic                sel_err_q;

    logic [DATA_W-1:0]   a_reg_q [N_A];
    logic [DATA_W-1:0]   a_reg_d [N_A];
    logic [N_A-1:0]      a_mask_q, a_mask_d;
    logic [SEL_W-1:0]    a_ptr_q, a_ptr_d;
    logic                a_err, a_acc, a_ready;

    logic [DATA_W-1:0]   b_reg_q [N_B];
    logic [DATA_W-1:0]   b_reg_d [N_B];
    logic [N_B-1:0]      b_mask_q, b_mask_d;
    logic [SEL_W-1:0]    b_ptr_q, b_ptr_d;
    logic                b_err, b_acc, b_ready;

    // A channel stalls in FULL, or in auto mode once its pointer is exhausted.
    assign a_ready = (state_q != ST_FULL) && !(bus_if.auto_mode && (a_ptr_q == A_END));
    assign b_ready = (state_q != ST_FULL) && !(bus_if.auto_mode && (b_ptr_q == B_END));
    assign a_acc   = bus_if.a_valid && a_ready;
    assign b_acc   = bus_if.b_valid && b_ready;

    // Channel A next bank contents for an accepted element.
    always_comb begin
        a_reg_d  = a_reg_q;
        a_mask_d = a_mask_q;
        a_ptr_d  = a_ptr_q;
        a_err    = 1'b0;
        if (a_acc) begin
            if (bus_if.auto_mode) begin
                for (int i = 0; i < N_A; i++) begin
                    if (a_ptr_q == SEL_W'(i)) begin
                        a_reg_d[i]  = bus_if.a_data;
                        a_mask_d[i] = 1'b1;
                    end
                end
                a_ptr_d = a_ptr_q + SEL_W'(1);
            end else if (bus_if.a_sel == SEL_CLR) begin
                for (int i = 0; i < N_A; i++) a_reg_d[i] = '0;
                a_mask_d = '0;
            end else if (bus_if.a_sel >= A_END) begin
                a_err = 1'b1;
            end else begin
                for (int i = 0; i < N_A; i++) begin
                    if (bus_if.a_sel == SEL_W'(i)) begin
                        a_reg_d[i]  = bus_if.a_data;
                        a_mask_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Channel B next bank contents for an accepted element.
    always_comb begin
        b_reg_d  = b_reg_q;
        b_mask_d = b_mask_q;
        b_ptr_d  = b_ptr_q;
        b_err    = 1'b0;
        if (b_acc) begin
            if (bus_if.auto_mode) begin
                for (int i = 0; i < N_B; i++) begin
                    if (b_ptr_q == SEL_W'(i)) begin
                        b_reg_d[i]  = bus_if.b_data;
                        b_mask_d[i] = 1'b1;
                    end
                end
                b_ptr_d = b_ptr_q + SEL_W'(1);
            end else if (bus_if.b_sel == SEL_CLR) begin
                for (int i = 0; i < N_B; i++) b_reg_d[i] = '0;
                b_mask_d = '0;
            end else if (bus_if.b_sel >= B_END) begin
                b_err = 1'b1;
            end else begin
                for (int i = 0; i < N_B; i++) begin
                    if (bus_if.b_sel == SEL_W'(i)) begin
                        b_reg_d[i]  = bus_if.b_data;
                        b_mask_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // FSM, banks, masks and pointers; clr overrides everything in its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus_if.clr) begin
            for (int i = 0; i < N_A; i++) a_reg_q[i] <= '0;
            for (int i = 0; i < N_B; i++) b_reg_q[i] <= '0;
            a_mask_q    <= '0;
            b_mask_q    <= '0;
            a_ptr_q     <= '0;
            b_ptr_q     <= '0;
            state_q     <= ST_EMPTY;
            bank_full_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            sel_err_q <= a_err | b_err;
            if ((state_q == ST_FULL) && bus_if.consume) begin
                // Data stays in the registers; only the bookkeeping restarts.
                a_mask_q    <= '0;
                b_mask_q    <= '0;
                a_ptr_q     <= '0;
                b_ptr_q     <= '0;
                state_q     <= ST_EMPTY;
                bank_full_q <= 1'b0;
            end else begin
                a_mask_q <= a_mask_d;
                b_mask_q <= b_mask_d;
                a_ptr_q  <= a_ptr_d;
                b_ptr_q  <= b_ptr_d;
                if ((&a_mask_d) && (&b_mask_d)) begin
                    state_q     <= ST_FULL;
                    bank_full_q <= 1'b1;
                end else if ((|a_mask_d) || (|b_mask_d)) begin
                    state_q     <= ST_LOAD;
                    bank_full_q <= 1'b0;
                end else begin
                    state_q     <= ST_EMPTY;
                    bank_full_q <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < N_A; g++) begin : g_a_pack
        assign bus_if.a_out[g*DATA_W +: DATA_W] = a_reg_q[g];
    end
    for (genvar g = 0; g < N_B; g++) begin : g_b_pack
        assign bus_if.b_out[g*DATA_W +: DATA_W] = b_reg_q[g];
    end

    assign bus_if.a_ready   = a_ready;
    assign bus_if.b_ready   = b_ready;
    assign bus_if.a_loaded  = a_mask_q;
    assign bus_if.b_loaded  = b_mask_q;
    assign bus_if.bank_full = bank_full_q;
    assign bus_if.sel_err   = sel_err_q;
    assign bus_if.state     = state_q;
endmodule

// File: tb/tb_demux_regbank_loader.sv
// Directed bench for demux_regbank_loader with default parameters.
module tb_demux_regbank_loader;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    demux_regbank_loader_if #(.DATA_W(16), .N_A(4), .N_B(6), .SEL_W(3)) bus ();

    demux_regbank_loader #(.DATA_W(16), .N_A(4), .N_B(6), .SEL_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        a_valid;
        logic [2:0]  a_sel;
        logic [15:0] a_data;
        logic        b_valid;
        logic [2:0]  b_sel;
        logic [15:0] b_data;
        logic        auto_mode;
        logic        clr;
        logic        consume;
        logic [3:0]  exp_a_loaded;
        logic [5:0]  exp_b_loaded;
        logic        exp_full;
        logic        exp_err;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic [1:0]  exp_state;
        logic [63:0] exp_a_out;
        logic [95:0] exp_b_out;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] asel, input logic [15:0] adata,
                         input logic bv, input logic [2:0] bsel, input logic [15:0] bdata,
                         input logic am, input logic cl, input logic cons);
        bus.a_valid   = av;
        bus.a_sel     = asel;
        bus.a_data    = adata;
        bus.b_valid   = bv;
        bus.b_sel     = bsel;
        bus.b_data    = bdata;
        bus.auto_mode = am;
        bus.clr       = cl;
        bus.consume   = cons;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_out"}, {32'h0, bus.a_out}, 96'h0);
        check({tag, "_b_out"}, bus.b_out, 96'h0);
        check({tag, "_a_loaded"}, {92'h0, bus.a_loaded}, 96'h0);
        check({tag, "_b_loaded"}, {90'h0, bus.b_loaded}, 96'h0);
        check({tag, "_state"}, {94'h0, bus.state}, 96'h0);
        check({tag, "_full"}, {95'h0, bus.bank_full}, 96'h0);
        check({tag, "_err"}, {95'h0, bus.sel_err}, 96'h0);
        check({tag, "_a_ready"}, {95'h0, bus.a_ready}, 96'h1);
        check({tag, "_b_ready"}, {95'h0, bus.b_ready}, 96'h1);
    endtask

    logic [95:0] exp_b;
    logic [63:0] exp_a;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // av asel adata bv bsel bdata auto clr cons | a_ld b_ld full err ar br st a_out b_out
        vecs[0]  = '{1, 0, 16'h0011, 1, 0, 16'h0021, 0, 0, 0, 4'b0001, 6'b000001, 0, 0, 1, 1, 2'd1,
                     64'h0000_0000_0000_0011, 96'h0000_0000_0000_0000_0000_0021};
        vecs[1]  = '{1, 1, 16'h0012, 1, 1, 16'h0022, 0, 0, 0, 4'b0011, 6'b000011, 0, 0, 1, 1, 2'd1,
                     64'h0000_0000_0012_0011, 96'h0000_0000_0000_0000_0022_0021};
        vecs[2]  = '{1, 2, 16'h0013, 1, 2, 16'h0023, 0, 0, 0, 4'b0111, 6'b000111, 0, 0, 1, 1, 2'd1,
                     64'h0000_0013_0012_0011, 96'h0000_0000_0000_0023_0022_0021};
        vecs[3]  = '{1, 3, 16'h0014, 1, 3, 16'h0024, 0, 0, 0, 4'b1111, 6'b001111, 0, 0, 1, 1, 2'd1,
                     64'h0014_0013_0012_0011, 96'h0000_0000_0024_0023_0022_0021};
        // overwrite of a loaded register
        vecs[4]  = '{1, 2, 16'h0033, 1, 4, 16'h0025, 0, 0, 0, 4'b1111, 6'b011111, 0, 0, 1, 1, 2'd1,
                     64'h0014_0033_0012_0011, 96'h0000_0025_0024_0023_0022_0021};
        // illegal select plus consume outside FULL
        vecs[5]  = '{0, 0, 16'h0000, 1, 6, 16'hBEEF, 0, 0, 1, 4'b1111, 6'b011111, 0, 1, 1, 1, 2'd1,
                     64'h0014_0033_0012_0011, 96'h0000_0025_0024_0023_0022_0021};
        vecs[6]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 4'b1111, 6'b011111, 0, 0, 1, 1, 2'd1,
                     64'h0014_0033_0012_0011, 96'h0000_0025_0024_0023_0022_0021};
        vecs[7]  = '{0, 0, 16'h0000, 1, 5, 16'h0026, 0, 0, 0, 4'b1111, 6'b111111, 1, 0, 0, 0, 2'd2,
                     64'h0014_0033_0012_0011, 96'h0026_0025_0024_0023_0022_0021};
        // write offered while FULL is not taken
        vecs[8]  = '{1, 0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, 4'b1111, 6'b111111, 1, 0, 0, 0, 2'd2,
                     64'h0014_0033_0012_0011, 96'h0026_0025_0024_0023_0022_0021};
        vecs[9]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 4'b0000, 6'b000000, 0, 0, 1, 1, 2'd0,
                     64'h0014_0033_0012_0011, 96'h0026_0025_0024_0023_0022_0021};
        // auto write lands at register 0, sel ignored
        vecs[10] = '{1, 3, 16'h0055, 0, 0, 16'h0000, 1, 0, 0, 4'b0001, 6'b000000, 0, 0, 1, 1, 2'd1,
                     64'h0014_0033_0012_0055, 96'h0026_0025_0024_0023_0022_0021};
        // manual channel clear of B only
        vecs[11] = '{0, 0, 16'h0000, 1, 7, 16'h0000, 0, 0, 0, 4'b0001, 6'b000000, 0, 0, 1, 1, 2'd1,
                     64'h0014_0033_0012_0055, 96'h0};
        // pointer kept across mode switch
        vecs[12] = '{1, 0, 16'h0056, 0, 0, 16'h0000, 1, 0, 0, 4'b0011, 6'b000000, 0, 0, 1, 1, 2'd1,
                     64'h0014_0033_0056_0055, 96'h0};
        // clr beats a write and an illegal select
        vecs[13] = '{1, 0, 16'h1234, 1, 6, 16'h0000, 0, 1, 0, 4'b0000, 6'b000000, 0, 0, 1, 1, 2'd0,
                     64'h0, 96'h0};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].a_valid, vecs[i].a_sel, vecs[i].a_data,
                  vecs[i].b_valid, vecs[i].b_sel, vecs[i].b_data,
                  vecs[i].auto_mode, vecs[i].clr, vecs[i].consume);
            step();
            check($sformatf("row%0d_a_loaded", i), {92'h0, bus.a_loaded}, {92'h0, vecs[i].exp_a_loaded});
            check($sformatf("row%0d_b_loaded", i), {90'h0, bus.b_loaded}, {90'h0, vecs[i].exp_b_loaded});
            check($sformatf("row%0d_full", i), {95'h0, bus.bank_full}, {95'h0, vecs[i].exp_full});
            check($sformatf("row%0d_err", i), {95'h0, bus.sel_err}, {95'h0, vecs[i].exp_err});
            check($sformatf("row%0d_a_ready", i), {95'h0, bus.a_ready}, {95'h0, vecs[i].exp_a_ready});
            check($sformatf("row%0d_b_ready", i), {95'h0, bus.b_ready}, {95'h0, vecs[i].exp_b_ready});
            check($sformatf("row%0d_state", i), {94'h0, bus.state}, {94'h0, vecs[i].exp_state});
            check($sformatf("row%0d_a_out", i), {32'h0, bus.a_out}, {32'h0, vecs[i].exp_a_out});
            check($sformatf("row%0d_b_out", i), bus.b_out, vecs[i].exp_b_out);
        end

        // Auto mode on B with arbitrary selects, A loading alongside.
        exp_b = '0;
        for (int k = 0; k < 6; k++) begin
            drive(k == 0, 0, 16'h0200, 1, 3'($urandom_range(0, 7)), 16'h0100 + 16'(k), 1, 0, 0);
            step();
            exp_b[k*16 +: 16] = 16'h0100 + 16'(k);
            check($sformatf("autob%0d_err", k), {95'h0, bus.sel_err}, 96'h0);
            check($sformatf("autob%0d_b_ready", k), {95'h0, bus.b_ready}, (k < 5) ? 96'h1 : 96'h0);
            check($sformatf("autob%0d_b_loaded", k), {90'h0, bus.b_loaded}, 96'((1 << (k + 1)) - 1));
        end
        check("autob_b_out", bus.b_out, exp_b);
        check("autob_a_loaded", {92'h0, bus.a_loaded}, 96'h1);
        check("autob_state", {94'h0, bus.state}, 96'h1);
        check("autob_a_ready", {95'h0, bus.a_ready}, 96'h1);
        // saturated pointer: no wrap onto register 0
        drive(0, 0, 0, 1, 0, 16'h0999, 1, 0, 0);
        step();
        check("autob_sat_b_out", bus.b_out, exp_b);
        check("autob_sat_b_loaded", {90'h0, bus.b_loaded}, 96'h3F);

        for (int k = 1; k < 4; k++) begin
            drive(1, 0, 16'h0200 + 16'(k), 0, 0, 0, 1, 0, 0);
            step();
            check($sformatf("autoa%0d_full", k), {95'h0, bus.bank_full}, (k == 3) ? 96'h1 : 96'h0);
        end
        exp_a = 64'h0203_0202_0201_0200;
        check("autoa_a_out", {32'h0, bus.a_out}, {32'h0, exp_a});
        check("autoa_state", {94'h0, bus.state}, 96'h2);
        check("autoa_a_ready", {95'h0, bus.a_ready}, 96'h0);
        check("autoa_b_ready", {95'h0, bus.b_ready}, 96'h0);

        // Consume in FULL, then an auto write restarts at register 0.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        step();
        check("cons_a_loaded", {92'h0, bus.a_loaded}, 96'h0);
        check("cons_b_loaded", {90'h0, bus.b_loaded}, 96'h0);
        check("cons_a_ready", {95'h0, bus.a_ready}, 96'h1);
        check("cons_b_ready", {95'h0, bus.b_ready}, 96'h1);
        check("cons_state", {94'h0, bus.state}, 96'h0);
        check("cons_a_out", {32'h0, bus.a_out}, {32'h0, exp_a});
        drive(1, 2, 16'h0777, 0, 0, 0, 1, 0, 0);
        step();
        check("cons_auto_a_out", {32'h0, bus.a_out}, {32'h0, 64'h0203_0202_0201_0777});
        check("cons_auto_a_loaded", {92'h0, bus.a_loaded}, 96'h1);

        // Asynchronous reset in the middle of a load.
        drive(1, 1, 16'hAAAA, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 2, 16'hBBBB, 0, 0, 0);
        step();
        check("pre_rst_a_loaded", {92'h0, bus.a_loaded}, 96'h3);
        check("pre_rst_b_loaded", {90'h0, bus.b_loaded}, 96'h4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        #1;
        rst = 1'b0;
        drive(1, 3, 16'h4242, 1, 5, 16'h4343, 1, 0, 0);
        step();
        check("post_rst_a_out", {32'h0, bus.a_out}, 96'h4242);
        check("post_rst_b_out", bus.b_out, 96'h4343);
        check("post_rst_a_loaded", {92'h0, bus.a_loaded}, 96'h1);
        check("post_rst_b_loaded", {90'h0, bus.b_loaded}, 96'h1);
        check("post_rst_state", {94'h0, bus.state}, 96'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_regbank_loader.md
DEMUX_REGBANK_LOADER -- requirements
Module: demux_regbank_loader

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, default 16, element width.
- N_A, default 4, channel-A register count.
- N_B, default 6, channel-B register count.
- SEL_W, default 3, select width; N_A and N_B SHALL each be at most 2^SEL_W-1.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  channel-A element offered.
- a_ready  out  1  channel-A element accepted this cycle if a_valid.
- a_data  in  DATA_W  channel-A element.
- a_sel  in  SEL_W  channel-A target index.
- b_valid, b_ready, b_data, b_sel  same as channel A, for channel B.
- auto_mode  in  1  1 = internal sequential pointers; 0 = use a_sel/b_sel.
- clr  in  1  synchronous clear of both banks.
- consume  in  1  downstream has taken a full bank.
- a_out  out  N_A*DATA_W  channel-A registers; register i at bits [i*DATA_W +: DATA_W].
- b_out  out  N_B*DATA_W  channel-B registers, same packing.
- a_loaded  out  N_A  per-register loaded mask.
- b_loaded  out  N_B  per-register loaded mask.
- bank_full  out  1  all registers in both banks loaded.
- sel_err  out  1  one-cycle pulse on an accepted illegal select.

Function
REQ-003 The block SHALL implement the FSM states EMPTY, LOAD and FULL.
- EMPTY: both masks are zero.
- LOAD: at least one mask bit is set and the banks are not full.
- FULL: bank_full=1.

REQ-004 A write SHALL be accepted on a channel when valid & ready are high at the rising edge; the data SHALL appear on the outputs on the following cycle, giving a latency of 1.

REQ-005 a_ready SHALL be asserted when the state is not FULL and not (auto_mode & a_ptr==N_A); b_ready SHALL be defined the same way.

REQ-006 Manual mode: an accepted element with sel<N SHALL write register[sel] and set loaded[sel].

REQ-007 Manual mode: sel equal to 2^SEL_W-1 SHALL zero every register of that channel and clear its mask; the other channel SHALL be unaffected.

REQ-008 Manual mode: sel in [N, 2^SEL_W-2] SHALL write nothing and pulse sel_err for one cycle.

REQ-009 A write to an already-loaded register SHALL overwrite its value, and the mask bit SHALL remain set.

REQ-010 Auto mode: an accepted element SHALL write register[ptr], set loaded[ptr] and increment ptr.
- ptr SHALL saturate at N and SHALL NOT wrap.
- sel SHALL be ignored, and sel_err SHALL NOT be raised.

REQ-011 Channels A and B SHALL operate independently, and simultaneous accepts on both channels SHALL both take effect in the same cycle.

REQ-012 The FSM SHALL enter FULL on the cycle after both masks become all-ones, and bank_full SHALL be asserted in that cycle.

REQ-013 In FULL, both readies SHALL be low and the registers SHALL hold their values.

REQ-014 consume in FULL SHALL clear both masks and both pointers and move the FSM to EMPTY next cycle; register data SHALL be retained.

REQ-015 consume outside FULL SHALL be ignored.

REQ-016 clr SHALL zero all registers, masks and pointers and move the FSM to EMPTY.
- clr SHALL have priority over same-cycle writes, consume and sel_err, which SHALL be discarded.

REQ-017 A change of auto_mode SHALL take effect on the next accept; the pointers SHALL be unchanged by the mode switch.

Reset
REQ-018 While rst=1, independent of clk, the block SHALL hold the following values:
- all registers = 0;
- a_loaded = 0 and b_loaded = 0;
- pointers = 0;
- state = EMPTY;
- bank_full = 0 and sel_err = 0;
- a_ready = 1 and b_ready = 1.

REQ-019 Reset asserted mid-load SHALL discard partial contents, and loading SHALL restart from EMPTY after release.

Verification
REQ-020 Manual fill: default parameters, 4 A writes (sel 0..3, data 0x0011..0x0014) and 6 B writes (sel 0..5, data 0x0021..0x0026).
- Required: a_out/b_out match the written data.
- Required: bank_full=1 one cycle after the last write, with both readies low.

REQ-021 Illegal select: b_sel=6 with data 0xBEEF.
- Required: sel_err pulses for 1 cycle; b_out and b_loaded are unchanged.
- Required: b_sel=7 then zeroes b_out and b_loaded only.

REQ-022 Auto mode: 6 B accepts of 0x0100..0x0105 with arbitrary b_sel.
- Required: register i = 0x0100+i.
- Required: b_ready is low after the 6th accept while A is still loading.

REQ-023 Simultaneous clr and write: clr together with a_valid (sel 0, data 0x1234).
- Required: a_out[0]=0, masks are 0, state is EMPTY.

REQ-024 Consume: consume in FULL.
- Required: masks are 0, readies are high next cycle, a_out data is retained.
- Required: a subsequent auto-mode write lands in register 0.

REQ-025 Asynchronous reset: rst pulsed between clock edges after 2 writes.
- Required: all outputs reach reset values immediately, without waiting for a clock edge.
